// File: rtl/le_if.sv
// Bus interface for the registered logic unit: operand/select inputs plus result and status flags.
// sel is 3 bits wide when LE_EXT_OPS_EN is defined, 2 bits otherwise.
interface le_if #(
    parameter int unsigned WIDTH = 4
);
`ifdef LE_EXT_OPS_EN
    localparam int unsigned SEL_W = 3;
`else
    localparam int unsigned SEL_W = 2;
`endif

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] e;
    logic             out_valid;
    logic             zero;
    logic             ones;

    modport master (
        output in_valid, a, b, sel,
        input  e, out_valid, zero, ones
    );

    modport slave (
        input  in_valid, a, b, sel,
        output e, out_valid, zero, ones
    );
endinterface

// File: rtl/le.sv
// Registered WIDTH-bit logic unit (AND/OR/XOR/NOT A) with valid strobe and zero/all-ones flags.
// Optional LE_EXT_OPS_EN adds the complemented forms NAND/NOR/XNOR/NOT B on sel[2].
module le #(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    le_if.slave  bus
);
    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] e_q, e_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;

    // Bitwise operation select; the fall-through case doubles as the guard against latching.
    always_comb begin
        res_c = ~bus.a;
`ifdef LE_EXT_OPS_EN
        case (bus.sel)
            3'b000:  res_c = bus.a & bus.b;
            3'b001:  res_c = bus.a | bus.b;
            3'b010:  res_c = bus.a ^ bus.b;
            3'b011:  res_c = ~bus.a;
            3'b100:  res_c = ~(bus.a & bus.b);
            3'b101:  res_c = ~(bus.a | bus.b);
            3'b110:  res_c = ~(bus.a ^ bus.b);
            default: res_c = ~bus.b;
        endcase
`else
        case (bus.sel)
            2'b00:   res_c = bus.a & bus.b;
            2'b01:   res_c = bus.a | bus.b;
            2'b10:   res_c = bus.a ^ bus.b;
            default: res_c = ~bus.a;
        endcase
`endif
    end

    // Flags derive from the same next-e value so they never disagree with e.
    always_comb begin
        e_d     = e_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            e_d     = res_c;
            zero_d  = (res_c == '0);
            ones_d  = &res_c;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q     <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
        end else begin
            e_q     <= e_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
        end
    end

    assign bus.e         = e_q;
    assign bus.out_valid = valid_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
endmodule

// File: tb/tb_le.sv
// Self-checking bench for le: directed cases plus randomized traffic against a truth-table model,
// run on WIDTH = 4 and WIDTH = 8 instances side by side.
module tb_le;
`ifdef LE_EXT_OPS_EN
    localparam int unsigned SEL_W = 3;
`else
    localparam int unsigned SEL_W = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       vin;
    logic [2:0] sel_in;
    logic [7:0] a_in;
    logic [7:0] b_in;

    int total = 0;
    int bad   = 0;

    // Reference state: what each instance should show after the latest edge.
    logic [7:0] m4_e, m8_e;
    logic       m4_v, m8_v, m4_z, m8_z, m4_o, m8_o;

    le_if #(.WIDTH(4)) bus4 ();
    le_if #(.WIDTH(8)) bus8 ();

    assign bus4.in_valid = vin;
    assign bus4.a        = a_in[3:0];
    assign bus4.b        = b_in[3:0];
    assign bus4.sel      = sel_in[SEL_W-1:0];
    assign bus8.in_valid = vin;
    assign bus8.a        = a_in;
    assign bus8.b        = b_in;
    assign bus8.sel      = sel_in[SEL_W-1:0];

    le #(.WIDTH(4)) u_le4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    le #(.WIDTH(8)) u_le8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Truth table per operation, indexed by {a_bit, b_bit}.
    function automatic logic [7:0] model_op(input logic [2:0] s, input logic [7:0] a,
                                            input logic [7:0] b, input int w);
        logic [3:0] tt;
        logic [7:0] r;
        case (s)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0011;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b0001;
            3'd6:    tt = 4'b1001;
            default: tt = 4'b0101;
        endcase
        r = 8'h00;
        for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic model_edge();
        logic [7:0] r4, r8;
        if (rst) begin
            m4_e = 8'h00; m4_v = 1'b0; m4_z = 1'b1; m4_o = 1'b0;
            m8_e = 8'h00; m8_v = 1'b0; m8_z = 1'b1; m8_o = 1'b0;
        end else if (vin) begin
            r4 = model_op(sel_in, a_in, b_in, 4);
            r8 = model_op(sel_in, a_in, b_in, 8);
            m4_e = r4; m4_v = 1'b1; m4_z = (r4 == 8'h00); m4_o = (r4 == 8'h0F);
            m8_e = r8; m8_v = 1'b1; m8_z = (r8 == 8'h00); m8_o = (r8 == 8'hFF);
        end else begin
            m4_v = 1'b0;
            m8_v = 1'b0;
        end
    endtask

    // One clock: advance the model on the edge, then compare both instances just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("e4",     8'(bus4.e),         m4_e);
        check("valid4", 8'(bus4.out_valid), 8'(m4_v));
        check("zero4",  8'(bus4.zero),      8'(m4_z));
        check("ones4",  8'(bus4.ones),      8'(m4_o));
        check("e8",     8'(bus8.e),         m8_e);
        check("valid8", 8'(bus8.out_valid), 8'(m8_v));
        check("zero8",  8'(bus8.zero),      8'(m8_z));
        check("ones8",  8'(bus8.ones),      8'(m8_o));
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] s,
                         input logic [7:0] a, input logic [7:0] b);
        rst = r; vin = v; sel_in = s; a_in = a; b_in = b;
    endtask

    // Directed op on the WIDTH=4 instance with a spec-derived constant result.
    task automatic op4(input string tag, input logic [2:0] s, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] exp_e);
        drive(1'b0, 1'b1, s, {4'h0, a}, {4'h0, b});
        step();
        check(tag, 8'(bus4.e), 8'(exp_e));
        check({tag, "_v"}, 8'(bus4.out_valid), 8'h01);
    endtask

    initial begin
        drive(1'b1, 1'b1, 3'd1, 8'hFF, 8'hFF);
        step();
        step();
        check("rst_e",    8'(bus4.e),         8'h00);
        check("rst_v",    8'(bus4.out_valid), 8'h00);
        check("rst_zero", 8'(bus4.zero),      8'h01);
        check("rst_ones", 8'(bus4.ones),      8'h00);

        op4("and",  3'd0, 4'b0101, 4'b0011, 4'b0001);
        op4("or",   3'd1, 4'b0101, 4'b0011, 4'b0111);
        op4("xor",  3'd2, 4'b0101, 4'b0011, 4'b0110);
        op4("nota", 3'd3, 4'b0101, 4'b0011, 4'b1010);

        op4("fz_and", 3'd0, 4'b1111, 4'b0000, 4'b0000);
        check("fz_zero", 8'(bus4.zero), 8'h01);
        op4("fo_or", 3'd1, 4'b1111, 4'b0000, 4'b1111);
        check("fo_ones", 8'(bus4.ones), 8'h01);
        check("fo_zero", 8'(bus4.zero), 8'h00);
        op4("fo_not", 3'd3, 4'b0000, 4'b0000, 4'b1111);
        check("fo_not_ones", 8'(bus4.ones), 8'h01);

        op4("hold_xor", 3'd2, 4'b1100, 4'b1010, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 3'd0, 8'hA5, 8'h5A);
            step();
            check("hold_e", 8'(bus4.e),         8'h06);
            check("hold_v", 8'(bus4.out_valid), 8'h00);
        end

        op4("mid_pre", 3'd0, 4'b1111, 4'b1111, 4'b1111);
        drive(1'b1, 1'b1, 3'd1, 8'h0C, 8'h03);
        step();
        check("mid_rst_e", 8'(bus4.e),         8'h00);
        check("mid_rst_v", 8'(bus4.out_valid), 8'h00);
        op4("mid_post", 3'd2, 4'b1001, 4'b0011, 4'b1010);

`ifdef LE_EXT_OPS_EN
        op4("nand", 3'd4, 4'b0101, 4'b0011, 4'b1110);
        op4("nor",  3'd5, 4'b0101, 4'b0011, 4'b1000);
        op4("xnor", 3'd6, 4'b0101, 4'b0011, 4'b1001);
        op4("notb", 3'd7, 4'b0101, 4'b0011, 4'b1100);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, (1 << SEL_W) - 1)),
                  8'($urandom), 8'($urandom));
            // Bias some operands toward the all-zero / all-one flag corners.
            if ($urandom_range(0, 7) == 0) a_in = 8'hFF;
            if ($urandom_range(0, 7) == 0) b_in = 8'h00;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/le.md
Name: le

Overview:
- Registered WIDTH-bit logic unit, after the Mano logic-circuit stage: bitwise AND, OR, XOR or NOT A of two operands, picked by a 2-bit select.
- Sits beside the arithmetic unit in the ALU datapath.
- Result is registered with one cycle of latency, plus a valid strobe and zero/all-ones flags for the status logic.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range is 1 or more).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies a, b and sel in the current cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sel  input  2  operation select (3 bits when LE_EXT_OPS_EN is defined).
- e  output  WIDTH  registered result.
- out_valid  output  1  e is valid for the operation accepted in the previous cycle.
- zero  output  1  registered flag; high when e equals all zeros.
- ones  output  1  registered flag; high when e equals all ones.

Behaviour:
- Reset: while rst is high at a rising edge, e = 0, out_valid = 0, zero = 1, ones = 0.
- rst takes priority over in_valid in the same cycle.
- Operation encoding, applied independently per bit:
  - sel 00: a AND b.
  - sel 01: a OR b.
  - sel 10: a XOR b.
  - sel 11: NOT a (b is ignored).
- Latency: inputs sampled with in_valid = 1 at edge N appear on e, zero and ones after edge N, with out_valid = 1.
- No backpressure; a new operation may be accepted every cycle at full throughput.
- in_valid = 0 at an edge (and rst low):
  - out_valid goes to 0.
  - e, zero and ones hold their previous values.
- zero and ones are computed from the same next-e value, so they are always consistent with e.
- If WIDTH = 1 and e = 1: ones = 1 and zero = 0.
- No carries and no cross-bit dependence; the result bits are fully independent.
- Reset asserted in the middle of a stream:
  - The pending result is discarded.
  - out_valid is 0 on the cycle after the reset edge.
  - The first valid input after rst falls produces output normally.
- X or undefined sel is not a legal input; the only requirement is that the block never latches. An implementation treating the default case as NOT a is acceptable.

Optional Feature:
- Macro LE_EXT_OPS_EN.
- Defined: sel is 3 bits.
  - sel[2] = 0 gives the four base operations above, keyed on sel[1:0].
  - sel[2] = 1 gives the complemented forms:
    - 100: NAND.
    - 101: NOR.
    - 110: XNOR.
    - 111: NOT b.
  - Flags, latency and reset behaviour are unchanged.
- Not defined:
  - sel is 2 bits.
  - Only the four base operations exist.
  - No extra logic is built.

Test Plan:
- Reset: hold rst high for 2 cycles with in_valid = 1 -> e = 0000, out_valid = 0, zero = 1, ones = 0.
- Base operations with a = 0101, b = 0011, one operation per cycle, in_valid = 1 (each result one cycle later, out_valid = 1):
  - sel 00 -> e = 0001.
  - sel 01 -> e = 0111.
  - sel 10 -> e = 0110.
  - sel 11 -> e = 1010.
- Flags:
  - a = 1111, b = 0000, sel 00 -> e = 0000, zero = 1.
  - sel 01 -> e = 1111, ones = 1, zero = 0.
  - a = 0000, sel 11 -> e = 1111, ones = 1.
- Hold: issue sel 10 with a = 1100, b = 1010 (e = 0110), then drop in_valid for 3 cycles -> e stays 0110, out_valid = 0.
- Reset mid-stream: back-to-back valid ops with rst pulsed for 1 cycle -> the op in flight is dropped, out_valid = 0 with e = 0 the next cycle, and the following op appears correctly.
- With LE_EXT_OPS_EN defined, a = 0101, b = 0011:
  - sel 100 -> 1110.
  - sel 101 -> 1000.
  - sel 110 -> 1001.
  - sel 111 -> 1100.
- Randomised background: compare against a bitwise reference model for WIDTH = 4 and WIDTH = 8.
